// File: rtl/counter_step_ctrl_if.sv
// Control/status bundle for counter_step_ctrl: the master drives the
// commands and the slave (the counter) returns the registered count and flags.
interface counter_step_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             dir;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] count_out;
    logic             tc;
    logic             ovf;
    logic             done;

    modport master (
        output clr, load, load_val, en, dir, step,
        input  count_out, tc, ovf, done
    );

    modport slave (
        input  clr, load, load_val, en, dir, step,
        output count_out, tc, ovf, done
    );
endinterface

// File: rtl/counter_step_ctrl.sv
// Up/down step counter over [0..MAX_VAL] with wrap, saturate or one-shot
// limit handling, terminal-count pulse, sticky overflow and one-shot done flag.
module counter_step_ctrl #(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = (1 << WIDTH) - 1,
    parameter int MODE    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    counter_step_ctrl_if.slave    bus
);
    localparam int MODE_WRAP    = 0;
    localparam int MODE_ONESHOT = 2;

    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MAX_VAL + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] diff;
    logic             up_over, up_reach, dn_under, dn_reach;
    logic             at_max, at_zero;

    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return (v > MAX_W) ? MAX_W : v;
    endfunction

    function automatic logic [WIDTH-1:0] sat_up(input logic [WIDTH:0] s);
        return (s >= MAX_EXT) ? MAX_W : WIDTH'(s);
    endfunction

    function automatic logic [WIDTH-1:0] wrap_up(input logic [WIDTH:0] s);
        return WIDTH'(s - MOD_EXT);
    endfunction

    // Underflow wrap: count + (MAX_VAL+1) - step stays below MAX_VAL+1.
    function automatic logic [WIDTH-1:0] wrap_dn(input logic [WIDTH-1:0] c,
                                                 input logic [WIDTH-1:0] s);
        return WIDTH'({1'b0, c} + MOD_EXT - {1'b0, s});
    endfunction

    assign sum_ext  = {1'b0, count_q} + {1'b0, bus.step};
    assign diff     = count_q - bus.step;
    assign up_over  = sum_ext > MAX_EXT;
    assign up_reach = sum_ext >= MAX_EXT;
    assign dn_under = bus.step > count_q;
    assign dn_reach = bus.step >= count_q;
    assign at_max   = count_q == MAX_W;
    assign at_zero  = count_q == '0;

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        done_d  = done_q;
        state_d = state_q;
        if (bus.clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
            done_d  = 1'b0;
            state_d = IDLE;
        end else if (bus.load) begin
            count_d = clamp_load(bus.load_val);
            done_d  = 1'b0;
            state_d = RUN;
        end else if (bus.en && state_q != DONE) begin
            if (state_q == IDLE) state_d = RUN;
            if (bus.step != '0) begin
                if (MODE == MODE_WRAP) begin
                    if (bus.dir) begin
                        count_d = up_over ? wrap_up(sum_ext) : WIDTH'(sum_ext);
                        tc_d    = up_over;
                        ovf_d   = ovf_q | up_over;
                    end else begin
                        count_d = dn_under ? wrap_dn(count_q, bus.step) : diff;
                        tc_d    = dn_under;
                        ovf_d   = ovf_q | dn_under;
                    end
                end else if (bus.dir) begin
                    count_d = sat_up(sum_ext);
                    // Saturate reports only the move onto the limit; one-shot
                    // treats any limit event as terminal.
                    if (up_reach && (MODE == MODE_ONESHOT || !at_max)) begin
                        tc_d  = 1'b1;
                        ovf_d = 1'b1;
                        if (MODE == MODE_ONESHOT) begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end
                    end
                end else begin
                    count_d = dn_reach ? '0 : diff;
                    if (dn_reach && (MODE == MODE_ONESHOT || !at_zero)) begin
                        tc_d  = 1'b1;
                        ovf_d = 1'b1;
                        if (MODE == MODE_ONESHOT) begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            state_q <= IDLE;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            state_q <= state_d;
        end
    end

    assign bus.count_out = count_q;
    assign bus.tc        = tc_q;
    assign bus.ovf       = ovf_q;
    assign bus.done      = (MODE == MODE_ONESHOT) ? done_q : 1'b0;
endmodule
